mem_arbiter: RTL and testbench

Two-port arbiter that shares one single-ported 16-bit-word memory between the CPU instruction-fetch port and the data (load/store) port. It sits between the cpu fetch/memory-stage logic and the unified memory model, serialising requests and returning registered read data with one-cycle acknowledge pulses. The data port has priority, and a starvation guard bounds instruction-fetch wait. A timeout watchdog aborts hung memory transactions.

---
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported 16-bit-word memory between the instruction-fetch
//   port (i_*) and the load/store port (d_*). The data port has priority; a
//   starvation guard hands the next grant to the fetch port after STARVE
//   consecutive data grants while a fetch is pending. A watchdog aborts any
//   memory transaction that stays unanswered for TIMEOUT busy cycles.
//
// Ports
//   clk, rst        clock, synchronous active-low reset
//   i_req/i_addr    fetch request (held until i_ack), word address
//   i_ack/i_rdata   one-cycle completion pulse, fetched word (held)
//   d_req/d_wr      data request (held until d_ack), 1 = store
//   d_addr/d_wdata  data word address, store data
//   d_ack/d_rdata   one-cycle completion pulse, load data (held)
//   err             one-cycle pulse with the ack of a timed-out access
//   mem_req/mem_wr  memory request level and write qualifier
//   mem_addr/wdata  latched address and store data
//   mem_ready/rdata memory completion and read data
module mem_arbiter #(
  parameter int STARVE  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ack,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata
);

  localparam int SW = $clog2(STARVE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_wr_q, mem_wr_d;
  logic [15:0]     mem_addr_q, mem_addr_d;
  logic [15:0]     mem_wdata_q, mem_wdata_d;
  logic            i_ack_q, i_ack_d;
  logic            d_ack_q, d_ack_d;
  logic            err_q, err_d;
  logic [15:0]     i_rdata_q, i_rdata_d;
  logic [15:0]     d_rdata_q, d_rdata_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  // A request seen during its own ack cycle is the requester still lowering
  // it, so it is not a new request.
  logic i_ok, d_ok, guard;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == STARVE_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    i_ok  = i_req & ~i_ack_q;
    d_ok  = d_req & ~d_ack_q;
    guard = (starve_q == STARVE_MAX) & i_ok;

    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (d_ok && !guard) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_wr_d    = d_wr;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          tmo_d       = '0;
          starve_d    = i_ok ? sat_inc(starve_q) : '0;
        end else if (i_ok) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = d_wdata;
          tmo_d       = '0;
          starve_d    = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        tmo_d = tmo_q + 1'b1;
        if (mem_ready || (tmo_q == TMO_LAST)) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
          err_d     = ~mem_ready;
          if (state_q == BUSY_I) begin
            i_ack_d = 1'b1;
            if (mem_ready) i_rdata_d = mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            // Stores leave the load-data register untouched.
            if (mem_ready && !mem_wr_q) d_rdata_d = mem_rdata;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      starve_q    <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter: reset, zero-wait load, other-port grant in
//   the ack cycle, wait-state store, starvation guard, timeout abort and
//   mid-transaction reset. The bench acts as both requesters and the memory.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ack;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        exp_i [6];
    logic        early;
    rst       = 1'b0;
    i_req     = 1'b1;
    i_addr    = 16'h0100;
    d_req     = 1'b1;
    d_wr      = 1'b0;
    d_addr    = 16'h0010;
    d_wdata   = 16'h0000;
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;

    // Reset held two cycles with both requests high.
    tick();
    tick();
    chk("rst_ctrl", {31'd0, mem_req, mem_wr, i_ack, d_ack, err}, 36'd0);
    chk("rst_mem", {4'd0, mem_addr, mem_wdata}, 36'd0);
    chk("rst_rdata", {4'd0, i_rdata, d_rdata}, 36'd0);

    // Release: data wins, zero-wait load of 0xBEEF from 0x0010.
    rst = 1'b1;
    tick();
    chk("load_grant", {17'd0, mem_req, mem_wr, mem_addr}, {17'd0, 1'b1, 1'b0, 16'h0010});
    mem_ready = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    chk("load_ack", {33'd0, d_ack, i_ack, mem_req}, {33'd0, 1'b1, 1'b0, 1'b0});
    chk("load_rdata", {20'd0, d_rdata}, {20'd0, 16'hBEEF});

    // Ack cycle: data masked, pending fetch is granted.
    mem_ready = 1'b0;
    d_req     = 1'b0;
    tick();
    chk("fetch_grant", {17'd0, mem_req, mem_wr, mem_addr}, {17'd0, 1'b1, 1'b0, 16'h0100});
    mem_ready = 1'b1;
    mem_rdata = 16'h5A5A;
    tick();
    chk("fetch_ack", {33'd0, i_ack, d_ack, err}, {33'd0, 1'b1, 1'b0, 1'b0});
    chk("fetch_rdata", {20'd0, i_rdata}, {20'd0, 16'h5A5A});
    mem_ready = 1'b0;
    i_req     = 1'b0;
    tick();
    chk("fetch_idle", {35'd0, mem_req}, 36'd0);

    // Store with three wait cycles.
    d_req   = 1'b1;
    d_wr    = 1'b1;
    d_addr  = 16'h0020;
    d_wdata = 16'h1234;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("store_busy%0d", k), {2'd0, mem_req, mem_wr, mem_addr, mem_wdata},
          {2'd0, 1'b1, 1'b1, 16'h0020, 16'h1234});
      chk($sformatf("store_noack%0d", k), {35'd0, d_ack}, 36'd0);
      mem_ready = (k == 3);
      mem_rdata = 16'hFFFF;
      tick();
    end
    chk("store_ack", {34'd0, d_ack, err}, {34'd0, 1'b1, 1'b0});
    chk("store_rdata", {20'd0, d_rdata}, {20'd0, 16'hBEEF});
    mem_ready = 1'b0;
    d_req     = 1'b0;
    d_wr      = 1'b0;
    tick();
    chk("store_pulse", {34'd0, d_ack, mem_req}, 36'd0);

    // Starvation: fetch pending at each data grant; fifth grant goes to fetch.
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    i_addr = 16'h0200;
    for (int r = 0; r < 6; r++) begin
      d_req  = 1'b1;
      d_addr = 16'h0030 + 16'(r);
      if (r < 5) i_req = 1'b1;
      tick();
      chk($sformatf("starve_grant%0d", r), {19'd0, mem_req, mem_addr},
          {19'd0, 1'b1, (exp_i[r] ? 16'h0200 : 16'h0030 + 16'(r))});
      mem_ready = 1'b1;
      mem_rdata = 16'hA000 + 16'(r);
      tick();
      chk($sformatf("starve_ack%0d", r), {34'd0, i_ack, d_ack}, {34'd0, exp_i[r], ~exp_i[r]});
      if (exp_i[r])
        chk($sformatf("starve_irdata%0d", r), {20'd0, i_rdata}, {20'd0, 16'hA004});
      else
        chk($sformatf("starve_drdata%0d", r), {20'd0, d_rdata}, {20'd0, 16'hA000 + 16'(r)});
      mem_ready = 1'b0;
      i_req     = 1'b0;
      if (!exp_i[r]) begin
        d_req = 1'b0;
        tick();
      end
    end

    // Timeout: fetch with no mem_ready is aborted after 64 busy cycles.
    i_req  = 1'b1;
    i_addr = 16'h0300;
    tick();
    chk("tmo_grant", {19'd0, mem_req, mem_addr}, {19'd0, 1'b1, 16'h0300});
    early = 1'b0;
    for (int k = 0; k < 63; k++) begin
      tick();
      early = early | i_ack | err;
    end
    chk("tmo_early", {34'd0, early, mem_req}, {34'd0, 1'b0, 1'b1});
    tick();
    chk("tmo_ack", {33'd0, i_ack, err, mem_req}, {33'd0, 1'b1, 1'b1, 1'b0});
    chk("tmo_rdata", {20'd0, i_rdata}, {20'd0, 16'hA004});
    i_req = 1'b0;
    tick();
    chk("tmo_idle", {33'd0, i_ack, err, mem_req}, 36'd0);

    // Reset in the second busy cycle of a load drops it without an ack.
    d_req  = 1'b1;
    d_wr   = 1'b0;
    d_addr = 16'h0040;
    tick();
    chk("mid_grant", {19'd0, mem_req, mem_addr}, {19'd0, 1'b1, 16'h0040});
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst", {33'd0, mem_req, d_ack, i_ack}, 36'd0);
    chk("mid_rst_regs", {4'd0, mem_addr, d_rdata}, 36'd0);
    rst       = 1'b1;
    d_req     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'h7777;
    tick();
    chk("late_ready", {32'd0, d_ack, i_ack, err, mem_req}, 36'd0);
    chk("late_rdata", {4'd0, d_rdata, i_rdata}, 36'd0);
    mem_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
